// File: rtl/ysyx_22041207_pkg.sv
// Shared types and widths for the IF/LS memory arbiter.
package ysyx_22041207_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22041207_arb_req_reg.sv
// Holds the granted request (address, direction, data, mask, owner) for the
// whole life of a memory transaction so requesters can move on after ready.
module ysyx_22041207_arb_req_reg #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          grant_ls,
  input  logic                          grant_if,
  input  logic                          ls_we,
  input  logic [ADDR_W-1:0]             ls_addr,
  input  logic [DATA_W-1:0]             ls_wdata,
  input  logic [7:0]                    ls_wmask,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic [ADDR_W-1:0]             addr_q,
  output logic                          we_q,
  output logic [DATA_W-1:0]             wdata_q,
  output logic [7:0]                    wmask_q,
  output ysyx_22041207_pkg::arb_owner_e owner_q
);
  import ysyx_22041207_pkg::*;

  // Capture the winning requester's fields on the grant edge; fetches are reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      owner_q <= OWN_IF;
    end else if (grant_ls) begin
      addr_q  <= ls_addr;
      we_q    <= ls_we;
      wdata_q <= ls_wdata;
      wmask_q <= ls_wmask;
      owner_q <= OWN_LS;
    end else if (grant_if) begin
      addr_q  <= if_addr;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      owner_q <= OWN_IF;
    end
  end

endmodule

// File: rtl/ysyx_22041207_mem_arb.sv
// Memory port arbiter: instruction fetch and load/store share one memory
// port, one transaction outstanding, LS has fixed priority over IF.
// Optional response timeout enabled by defining YSYX_ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | no transaction; grant LS first, else IF (comb ready)
// ST_ISSUE | mem_req_valid high with latched fields until mem_req_ready
// ST_WAIT  | waiting for mem_resp_valid (or timeout), then route to owner
module ysyx_22041207_mem_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
`ifdef YSYX_ARB_TIMEOUT_EN
  , parameter int TMO_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [7:0]        ls_wmask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              pc_delay,
  output logic              arb_err
);
  import ysyx_22041207_pkg::*;

  arb_state_e state_q, state_d;
  arb_owner_e owner_q;
  logic       resp_fire;
  logic       tmo_fire;
  logic       tmo_hit;

  ysyx_22041207_arb_req_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_reg (
    .clk      (clk),
    .rst      (rst),
    .grant_ls (ls_req_ready),
    .grant_if (if_req_ready),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_wmask (ls_wmask),
    .if_addr  (if_addr),
    .addr_q   (mem_addr),
    .we_q     (mem_we),
    .wdata_q  (mem_wdata),
    .wmask_q  (mem_wmask),
    .owner_q  (owner_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, grants and memory request strobe.
  always_comb begin
    state_d       = state_q;
    ls_req_ready  = 1'b0;
    if_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    resp_fire     = 1'b0;
    tmo_fire      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ls_req_valid) begin
          ls_req_ready = 1'b1;
          state_d      = ST_ISSUE;
        end else if (if_req_valid) begin
          if_req_ready = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          resp_fire = 1'b1;
          state_d   = ST_IDLE;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered one-cycle response to the owner; a timeout answers with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      ls_resp_data  <= '0;
    end else begin
      if_resp_valid <= (resp_fire | tmo_fire) & (owner_q == OWN_IF);
      ls_resp_valid <= (resp_fire | tmo_fire) & (owner_q == OWN_LS);
      if (resp_fire | tmo_fire) begin
        if (owner_q == OWN_IF)
          if_resp_data <= tmo_fire   ? 32'h0 :
                          mem_addr[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
        else
          ls_resp_data <= (tmo_fire | mem_we) ? '0 : mem_resp_data;
      end
    end
  end

`ifdef YSYX_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       arb_err_q;

  // Down-counter loaded on entry to WAIT; terminal count at zero means TMO_CYC WAIT cycles elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      arb_err_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE && mem_req_ready)
        tmo_cnt_q <= 8'(TMO_CYC - 1);
      else if (state_q == ST_WAIT && tmo_cnt_q != 8'd0)
        tmo_cnt_q <= tmo_cnt_q - 8'd1;
      if (tmo_fire) arb_err_q <= 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt_q == 8'd0);
  assign arb_err = arb_err_q;
`else
  assign tmo_hit = 1'b0;
  assign arb_err = 1'b0;
`endif

  // Hold the PC while a fetch is waiting for a grant or owns the memory port.
  assign pc_delay = (if_req_valid & ~if_resp_valid) |
                    ((state_q != ST_IDLE) & (owner_q == OWN_IF));

  // Requesters must keep a request up until it is accepted.
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (if_req_valid && !if_req_ready) |=> if_req_valid);
  a_ls_hold: assert property (@(posedge clk) disable iff (rst)
    (ls_req_valid && !ls_req_ready) |=> ls_req_valid);

endmodule

// File: tb/tb_ysyx_22041207_mem_arb.sv
// Directed bench for the IF/LS memory arbiter; timeout section builds only
// with YSYX_ARB_TIMEOUT_EN.
module tb_ysyx_22041207_mem_arb;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid, if_req_ready, if_resp_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_resp_data;
  logic              ls_req_valid, ls_req_ready, ls_we, ls_resp_valid;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata, ls_resp_data;
  logic [7:0]        ls_wmask;
  logic              mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_resp_data;
  logic [7:0]        mem_wmask;
  logic              pc_delay, arb_err;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  logic count_en = 1'b0;
  logic [31:0] bb_exp [4];

  ysyx_22041207_mem_arb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef YSYX_ARB_TIMEOUT_EN
    , .TMO_CYC(4)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_resp_data   (if_resp_data),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_we          (ls_we),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_wmask       (ls_wmask),
    .ls_resp_valid  (ls_resp_valid),
    .ls_resp_data   (ls_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .pc_delay       (pc_delay),
    .arb_err        (arb_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (count_en && if_resp_valid) n_pulse++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 0; if_addr = '0;
    ls_req_valid = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1; mem_resp_valid = 0; mem_resp_data = '0;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_if_ready",  if_req_ready,  0);
    chk("rst_ls_ready",  ls_req_ready,  0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_if_resp",   if_resp_valid, 0);
    chk("rst_ls_resp",   ls_resp_valid, 0);
    chk("rst_arb_err",   arb_err,       0);
    chk("rst_pc_delay",  pc_delay,      0);
    chk("rst_mem_addr",  mem_addr,      0);
    chk("rst_if_data",   if_resp_data,  0);

    // IF only, upper half selected by addr[2]
    step();
    if_req_valid = 1; if_addr = 64'h8000_0004; #1;
    chk("if_ready_N", if_req_ready, 1);
    chk("if_pcd_N",   pc_delay,     1);
    step();
    if_req_valid = 0; #1;
    chk("if_memv_N1",  mem_req_valid, 1);
    chk("if_addr_N1",  mem_addr,      64'h8000_0004);
    chk("if_we_N1",    mem_we,        0);
    chk("if_pcd_N1",   pc_delay,      1);
    step();
    mem_resp_valid = 1; mem_resp_data = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    chk("if_memv_N2", mem_req_valid, 0);
    chk("if_pcd_N2",  pc_delay,      1);
    step();
    mem_resp_valid = 0; #1;
    chk("if_resp_N3", if_resp_valid, 1);
    chk("if_data_N3", if_resp_data,  32'hAAAA_BBBB);
    chk("if_pcd_N3",  pc_delay,      0);
    step();
    chk("if_resp_N4", if_resp_valid, 0);

    // IF and LS together: LS load wins, IF granted when LS response pulses
    if_req_valid = 1; if_addr = 64'h8000_0008;
    ls_req_valid = 1; ls_we = 0; ls_addr = 64'h8000_1000; #1;
    chk("both_ls_ready", ls_req_ready, 1);
    chk("both_if_ready", if_req_ready, 0);
    chk("both_pcd",      pc_delay,     1);
    step();
    ls_req_valid = 0; #1;
    chk("both_mem_addr", mem_addr,     64'h8000_1000);
    chk("both_if_wait",  if_req_ready, 0);
    step();
    mem_resp_valid = 1; mem_resp_data = 64'h1122_3344_5566_7788; #1;
    step();
    mem_resp_valid = 0; #1;
    chk("both_ls_resp",  ls_resp_valid, 1);
    chk("both_ls_data",  ls_resp_data,  64'h1122_3344_5566_7788);
    chk("both_if_grant", if_req_ready,  1);
    step();
    if_req_valid = 0; #1;
    chk("both_if_addr",  mem_addr,      64'h8000_0008);
    chk("both_ls_pulse", ls_resp_valid, 0);
    step();
    mem_resp_valid = 1; mem_resp_data = 64'hDEAD_BEEF_CAFE_F00D; #1;
    step();
    mem_resp_valid = 0; #1;
    chk("both_if_resp", if_resp_valid, 1);
    chk("both_if_data", if_resp_data,  32'hCAFE_F00D);
    step();

    // LS store with memory stalling the request for three cycles
    ls_req_valid = 1; ls_we = 1; ls_addr = 64'h8000_2010;
    ls_wdata = 64'h0123_4567_89AB_CDEF; ls_wmask = 8'h0F; mem_req_ready = 0; #1;
    chk("st_ready", ls_req_ready, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      ls_req_valid = 0; ls_addr = 64'h0; ls_wdata = 64'h0; ls_wmask = 8'h0; #1;
      chk("st_memv",  mem_req_valid, 1);
      chk("st_we",    mem_we,        1);
      chk("st_addr",  mem_addr,      64'h8000_2010);
      chk("st_wdata", mem_wdata,     64'h0123_4567_89AB_CDEF);
      chk("st_wmask", mem_wmask,     8'h0F);
    end
    step();
    mem_req_ready = 1; #1;
    chk("st_memv_acc", mem_req_valid, 1);
    step();
    mem_resp_valid = 1; mem_resp_data = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    chk("st_memv_wait", mem_req_valid, 0);
    chk("st_no_early",  ls_resp_valid, 0);
    step();
    mem_resp_valid = 0; #1;
    chk("st_ack",      ls_resp_valid, 1);
    chk("st_ack_data", ls_resp_data,  0);
    step();
    chk("st_ack_once", ls_resp_valid, 0);

    // Reset while waiting for a fetch response; late response is dropped
    if_req_valid = 1; if_addr = 64'h8000_0010; #1;
    chk("rw_grant", if_req_ready, 1);
    step();
    if_req_valid = 0;
    step();
    rst = 1; #1;
    chk("rw_pcd_wait", pc_delay, 1);
    step();
    rst = 0; mem_resp_valid = 1; mem_resp_data = 64'h5555_6666_7777_8888; #1;
    chk("rw_pcd_idle", pc_delay,      0);
    chk("rw_memv",     mem_req_valid, 0);
    step();
    mem_resp_valid = 0; #1;
    chk("rw_no_if_resp", if_resp_valid, 0);
    chk("rw_no_ls_resp", ls_resp_valid, 0);
    chk("rw_if_data",    if_resp_data,  0);
    step();

    // Four back-to-back fetches alternating lower/upper halves
    bb_exp[0] = 32'hB000_0000; bb_exp[1] = 32'hA000_0001;
    bb_exp[2] = 32'hB000_0002; bb_exp[3] = 32'hA000_0003;
    count_en = 1; n_pulse = 0;
    for (int i = 0; i < 4; i++) begin
      if_req_valid = 1; if_addr = 64'h8000_0000 + 64'(4 * i); mem_resp_valid = 0; #1;
      chk("bb_grant", if_req_ready, 1);
      if (i > 0) begin
        chk("bb_resp_v", if_resp_valid, 1);
        chk("bb_data",   if_resp_data,  bb_exp[i-1]);
      end
      step();
      if_req_valid = 0; #1;
      chk("bb_addr", mem_addr, 64'h8000_0000 + 64'(4 * i));
      step();
      mem_resp_valid = 1;
      mem_resp_data = {32'(32'hA000_0000 + i), 32'(32'hB000_0000 + i)};
      step();
    end
    mem_resp_valid = 0; #1;
    chk("bb_resp_v_last", if_resp_valid, 1);
    chk("bb_data_last",   if_resp_data,  bb_exp[3]);
    step(); step(); step();
    count_en = 0;
    chk("bb_pulses", 64'(n_pulse), 4);

`ifdef YSYX_ARB_TIMEOUT_EN
    // LS load with no memory response: timeout after four WAIT cycles
    ls_req_valid = 1; ls_we = 0; ls_addr = 64'h8000_3000; #1;
    chk("to_grant", ls_req_ready, 1);
    step();
    ls_req_valid = 0;
    step(); step(); step(); step(); #1;
    chk("to_err_pre",  arb_err,       0);
    chk("to_resp_pre", ls_resp_valid, 0);
    step();
    chk("to_err",      arb_err,       1);
    chk("to_resp",     ls_resp_valid, 1);
    chk("to_data",     ls_resp_data,  0);
    chk("to_memv",     mem_req_valid, 0);
    step(); step(); step();
    chk("to_sticky",   arb_err,       1);
    chk("to_idle",     ls_resp_valid, 0);
    rst = 1; step();
    rst = 0; #1;
    chk("to_cleared",  arb_err,       0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
